// File: rtl/iddmm_feeder.sv
// Job front-end for the IDDMM Montgomery core: streams operands into the core RAMs,
// hands the job to the core, buffers its N result words and replays them with backpressure.
//
// state   | meaning
// IDLE    | waiting for x[0]; result drain may still be running
// LD_X    | writing x words 1..N-1
// LD_Y    | writing y words
// LD_M    | writing m words (full mode only)
// LD_M1   | latching the m1 word (full mode only)
// REQ     | waiting for an empty result buffer, then requesting the core
// WAIT    | granted, waiting for the first result word
// COLLECT | capturing result words into the buffer
module iddmm_feeder #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [K-1:0]      s_data,
  input  logic              s_reuse_m,
  output logic [2:0]        wr_ena,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [K-1:0]      wr_x,
  output logic [K-1:0]      wr_y,
  output logic [K-1:0]      wr_m,
  output logic [K-1:0]      wr_m1,
  output logic              task_req,
  input  logic              task_grant,
  input  logic              task_end,
  input  logic [K-1:0]      task_res,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [K-1:0]      r_data,
  output logic              r_last,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, LD_X, LD_Y, LD_M, LD_M1, REQ, WAIT, COLLECT} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  state_t            state;
  logic              full_mode;
  logic              m_loaded;
  logic              buf_full;
  logic [ADDR_W-1:0] wcnt;
  logic [ADDR_W-1:0] rcnt;
  logic [ADDR_W-1:0] dcnt;
  logic [K-1:0]      res_buf [N];

  logic accept;
  logic collecting;
  logic buf_we;
  logic drain;

  assign accept     = s_valid && s_ready;
  assign collecting = (state == WAIT) || (state == COLLECT);
  assign buf_we     = task_end && collecting;
  assign drain      = r_valid && r_ready;
  assign busy       = (state != IDLE);
  assign r_valid    = buf_full;
  assign r_last     = buf_full && (dcnt == LAST);
  assign r_data     = buf_full ? res_buf[dcnt] : '0;

  always_ff @(posedge clk) begin
    if (buf_we) res_buf[rcnt] <= task_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s_ready   <= 1'b0;
      wr_ena    <= 3'b000;
      wr_addr   <= '0;
      wr_x      <= '0;
      wr_y      <= '0;
      wr_m      <= '0;
      wr_m1     <= '0;
      task_req  <= 1'b0;
      full_mode <= 1'b0;
      m_loaded  <= 1'b0;
      buf_full  <= 1'b0;
      wcnt      <= '0;
      rcnt      <= '0;
      dcnt      <= '0;
      err       <= 1'b0;
    end else begin
      wr_ena <= 3'b000;
      if (accept && state != LD_M1) wr_addr <= wcnt;
      if (task_end && !collecting) err <= 1'b1;

      // Drain runs independently of the FSM; collection never overlaps it.
      if (drain) begin
        if (dcnt == LAST) begin
          dcnt     <= '0;
          buf_full <= 1'b0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (accept) begin
            full_mode <= !(s_reuse_m && m_loaded);
            wr_ena    <= 3'b001;
            wr_x      <= s_data;
            wcnt      <= ADDR_W'(1);
            state     <= LD_X;
          end
        end
        LD_X: if (accept) begin
          wr_ena <= 3'b001;
          wr_x   <= s_data;
          if (wcnt == LAST) begin
            wcnt  <= '0;
            state <= LD_Y;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        LD_Y: if (accept) begin
          wr_ena <= 3'b010;
          wr_y   <= s_data;
          if (wcnt == LAST) begin
            wcnt    <= '0;
            state   <= full_mode ? LD_M : REQ;
            s_ready <= full_mode;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        LD_M: if (accept) begin
          wr_ena <= 3'b100;
          wr_m   <= s_data;
          if (wcnt == LAST) begin
            wcnt  <= '0;
            state <= LD_M1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        LD_M1: if (accept) begin
          wr_m1    <= s_data;
          m_loaded <= 1'b1;
          s_ready  <= 1'b0;
          state    <= REQ;
        end
        REQ: begin
          if (task_req) begin
            if (task_grant) begin
              task_req <= 1'b0;
              state    <= WAIT;
            end
          end else if (!buf_full) begin
            task_req <= 1'b1;
          end
        end
        WAIT, COLLECT: if (task_end) begin
          state <= COLLECT;
          if (rcnt == LAST) begin
            rcnt     <= '0;
            buf_full <= 1'b1;
            s_ready  <= 1'b1;
            state    <= IDLE;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iddmm_feeder.sv
// Bench for iddmm_feeder: random operand jobs, a behavioural core emulator returning
// random result words, and a monitor logging core writes and delivered results.
module tb_iddmm_feeder;
  localparam int K  = 16;
  localparam int N  = 4;
  localparam int AW = 2;

  typedef logic [63:0] rec_t;
  typedef rec_t recq_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [K-1:0]  s_data;
  logic          s_reuse_m;
  logic [2:0]    wr_ena;
  logic [AW-1:0] wr_addr;
  logic [K-1:0]  wr_x, wr_y, wr_m, wr_m1;
  logic          task_req;
  logic          task_grant = 1'b0;
  logic          task_end = 1'b0;
  logic [K-1:0]  task_res = '0;
  logic          r_valid;
  logic          r_ready;
  logic [K-1:0]  r_data;
  logic          r_last;
  logic          busy;
  logic          err;

  int checks = 0;
  int failures = 0;

  recq_t wr_log, got_res, exp_res;
  int req_cycles = 0;
  bit mdl_m_loaded = 0;
  logic [K-1:0] mdl_m1 = '0;
  int grant_delay = 0;
  int spur_cnt = 0, spur_done = 0;
  int phase = 0, gcnt = 0, res_i = 0;

  iddmm_feeder #(.K(K), .N(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_reuse_m(s_reuse_m), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
    .wr_m(wr_m), .wr_m1(wr_m1), .task_req(task_req), .task_grant(task_grant),
    .task_end(task_end), .task_res(task_res), .r_valid(r_valid), .r_ready(r_ready),
    .r_data(r_data), .r_last(r_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Core emulator: grant after grant_delay cycles, then N contiguous result words.
  always @(negedge clk) begin
    task_grant = 1'b0;
    task_end   = 1'b0;
    if (rst) begin
      phase = 0;
    end else begin
      if (phase == 2) begin
        task_end = 1'b1;
        task_res = K'($urandom);
        exp_res.push_back(rec_t'({(res_i == N - 1), task_res}));
        res_i++;
        if (res_i == N) phase = 0;
      end else begin
        if (phase == 0 && task_req) begin
          gcnt  = grant_delay;
          phase = 1;
        end
        if (phase == 1) begin
          if (gcnt == 0) begin
            task_grant = 1'b1;
            phase      = 2;
            res_i      = 0;
          end else begin
            gcnt--;
          end
        end
      end
      if (phase == 0 && !task_end && spur_cnt != spur_done) begin
        task_end = 1'b1;
        task_res = K'($urandom);
        spur_done++;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (wr_ena != 3'b000)
        wr_log.push_back(rec_t'({wr_ena, wr_addr, wr_ena[0] ? wr_x : (wr_ena[1] ? wr_y : wr_m)}));
      if (r_valid && r_ready) got_res.push_back(rec_t'({r_last, r_data}));
      if (task_req) req_cycles++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic int count_diff(recq_t got, int start, recq_t want);
    int d = 0;
    if (got.size() - start != want.size()) d++;
    for (int i = 0; i < want.size(); i++)
      if (start + i >= got.size() || got[start + i] !== want[i]) d++;
    return d;
  endfunction

  task automatic send_words(input recq_t ops, input bit reuse, input bit gaps, output int cycles);
    int i = 0;
    cycles = 0;
    while (i < ops.size() && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      s_valid   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data    = K'(ops[i]);
      s_reuse_m = reuse;
      if (s_valid && s_ready) i++;
    end
  endtask

  // Builds a job from the operand rules and records the core writes it must cause.
  task automatic run_load(input bit reuse, input bit gaps, input bit fixed,
                          output recq_t expw, output int cycles);
    recq_t ops;
    bit full;
    logic [K-1:0] w;
    full = !(reuse && mdl_m_loaded);
    expw = {};
    for (int s = 0; s < (full ? 3 : 2); s++) begin
      for (int a = 0; a < N; a++) begin
        w = fixed ? K'(s * N + a + 1) : K'($urandom);
        ops.push_back(rec_t'(w));
        expw.push_back(rec_t'({3'(1 << s), AW'(a), w}));
      end
    end
    if (full) begin
      w = fixed ? 16'hBEEF : K'($urandom);
      ops.push_back(rec_t'(w));
      mdl_m1       = w;
      mdl_m_loaded = 1;
    end
    send_words(ops, reuse, gaps, cycles);
  endtask

  task automatic wait_done(input int target, output bit ok);
    int t = 0;
    while (t < 400 && !(got_res.size() >= target && !busy && !r_valid)) begin
      @(negedge clk);
      t++;
    end
    ok = (t < 400);
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_reuse_m = 1'b0; r_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_ready, wr_ena, task_req, r_valid, r_last, busy, err} !== '0)
      $display("FAIL reset_ctrl got=%b want=0", {s_ready, wr_ena, task_req, r_valid, r_last, busy, err});
    checks++;
    if ({wr_addr, wr_x, wr_y, wr_m, wr_m1, r_data} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h want=0", {wr_addr, wr_x, wr_y, wr_m, wr_m1, r_data});
    end
    if ({s_ready, wr_ena, task_req, r_valid, r_last, busy, err} !== '0) failures++;
    rst = 1'b0;
    mdl_m_loaded = 0;
    mdl_m1 = '0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_ready got=%b want=1", s_ready);
    end
  endtask

  task automatic test_reuse_first();
    recq_t expw; int cyc, ws, d; bit ok;
    ws = wr_log.size();
    run_load(1'b1, 1'b0, 1'b0, expw, cyc);
    @(negedge clk); s_valid = 1'b0;
    checks++;
    if (cyc !== 3 * N + 1) begin
      failures++;
      $display("FAIL reuse_first_cycles got=%0d want=%0d", cyc, 3 * N + 1);
    end
    wait_done(got_res.size() + N, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL reuse_first_done got=timeout want=done"); end
    d = count_diff(wr_log, ws, expw);
    checks++;
    if (d != 0) begin failures++; $display("FAIL reuse_first_writes diffs=%0d want=0", d); end
    checks++;
    if (wr_m1 !== mdl_m1) begin
      failures++;
      $display("FAIL reuse_first_m1 got=%h want=%h", wr_m1, mdl_m1);
    end
  endtask

  task automatic test_full_job();
    recq_t expw; int cyc, ws, d; bit ok;
    ws = wr_log.size();
    run_load(1'b0, 1'b0, 1'b1, expw, cyc);
    @(negedge clk); s_valid = 1'b0;
    checks++;
    if (task_req !== 1'b0 || wr_m1 !== 16'hBEEF) begin
      failures++;
      $display("FAIL full_m1_write got req=%b m1=%h want req=0 m1=beef", task_req, wr_m1);
    end
    @(negedge clk);
    checks++;
    if (task_req !== 1'b1) begin
      failures++;
      $display("FAIL full_req_latency got=%b want=1", task_req);
    end
    wait_done(got_res.size() + N, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL full_done got=timeout want=done"); end
    d = count_diff(wr_log, ws, expw);
    checks++;
    if (d != 0) begin failures++; $display("FAIL full_writes diffs=%0d want=0", d); end
    d = count_diff(got_res, 0, exp_res);
    checks++;
    if (d != 0) begin failures++; $display("FAIL full_results diffs=%0d want=0", d); end
  endtask

  task automatic test_reuse_job();
    recq_t expw; int cyc, ws, d; bit ok;
    ws = wr_log.size();
    run_load(1'b1, 1'b0, 1'b0, expw, cyc);
    @(negedge clk); s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (task_req !== 1'b1 || cyc !== 2 * N) begin
      failures++;
      $display("FAIL reuse_req got req=%b cycles=%0d want req=1 cycles=%0d", task_req, cyc, 2 * N);
    end
    wait_done(got_res.size() + N, ok);
    d = count_diff(wr_log, ws, expw);
    checks++;
    if (!ok || d != 0) begin
      failures++;
      $display("FAIL reuse_writes ok=%0d diffs=%0d want ok=1 diffs=0", ok, d);
    end
    checks++;
    if (wr_m1 !== mdl_m1) begin
      failures++;
      $display("FAIL reuse_m1_held got=%h want=%h", wr_m1, mdl_m1);
    end
    d = count_diff(got_res, 0, exp_res);
    checks++;
    if (d != 0) begin failures++; $display("FAIL reuse_results diffs=%0d want=0", d); end
  endtask

  task automatic test_backpressure();
    recq_t expw; int cyc, t, tgt, d; bit ok, held;
    logic [K-1:0] first_word;
    tgt = got_res.size() + 2 * N;
    r_ready = 1'b0;
    run_load(1'b1, 1'b0, 1'b0, expw, cyc);
    @(negedge clk); s_valid = 1'b0;
    t = 0;
    while (!r_valid && t < 200) begin @(negedge clk); t++; end
    first_word = K'(exp_res[exp_res.size() - N]);
    run_load(1'b1, 1'b0, 1'b0, expw, cyc);
    @(negedge clk); s_valid = 1'b0;
    held = 1;
    repeat (10) begin
      @(negedge clk);
      if (task_req !== 1'b0 || r_valid !== 1'b1) held = 0;
    end
    checks++;
    if (!held) begin failures++; $display("FAIL bp_req_held got=0 want=1"); end
    checks++;
    if (r_data !== first_word || r_last !== 1'b0) begin
      failures++;
      $display("FAIL bp_head got=%h last=%b want=%h last=0", r_data, r_last, first_word);
    end
    r_ready = 1'b1;
    wait_done(tgt, ok);
    d = count_diff(got_res, 0, exp_res);
    checks++;
    if (!ok || d != 0) begin
      failures++;
      $display("FAIL bp_results ok=%0d diffs=%0d want ok=1 diffs=0", ok, d);
    end
  endtask

  task automatic test_gaps();
    recq_t expw; int cyc, ws, r0, d; bit ok;
    grant_delay = 5;
    ws = wr_log.size();
    r0 = req_cycles;
    run_load(1'b0, 1'b1, 1'b0, expw, cyc);
    @(negedge clk); s_valid = 1'b0;
    wait_done(got_res.size() + N, ok);
    checks++;
    if (req_cycles - r0 != 6) begin
      failures++;
      $display("FAIL gaps_req_width got=%0d want=6", req_cycles - r0);
    end
    d = count_diff(wr_log, ws, expw);
    checks++;
    if (!ok || d != 0) begin
      failures++;
      $display("FAIL gaps_writes ok=%0d diffs=%0d want ok=1 diffs=0", ok, d);
    end
    d = count_diff(got_res, 0, exp_res);
    checks++;
    if (d != 0) begin failures++; $display("FAIL gaps_results diffs=%0d want=0", d); end
    grant_delay = 0;
  endtask

  task automatic test_spurious();
    spur_cnt++;
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL spurious_err got=%b want=1", err); end
    checks++;
    if (r_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL spurious_buffer got valid=%b busy=%b want 0 0", r_valid, busy);
    end
  endtask

  task automatic test_rst_mid();
    recq_t ops, expw; int cyc, ws, d; bit ok;
    for (int i = 0; i < N + 2; i++) ops.push_back(rec_t'($urandom));
    send_words(ops, 1'b0, 1'b0, cyc);
    @(negedge clk); s_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_ready, wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1, task_req, r_valid, r_data, r_last, busy, err} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%h want=0",
               {s_ready, wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1, task_req, r_valid, r_data, r_last, busy, err});
    end
    rst = 1'b0;
    mdl_m_loaded = 0;
    mdl_m1 = '0;
    @(negedge clk);
    ws = wr_log.size();
    run_load(1'b1, 1'b0, 1'b0, expw, cyc);
    @(negedge clk); s_valid = 1'b0;
    wait_done(got_res.size() + N, ok);
    d = count_diff(wr_log, ws, expw);
    checks++;
    if (!ok || d != 0 || cyc != 3 * N + 1) begin
      failures++;
      $display("FAIL rst_mid_refull ok=%0d diffs=%0d cycles=%0d want 1 0 %0d", ok, d, cyc, 3 * N + 1);
    end
    d = count_diff(got_res, 0, exp_res);
    checks++;
    if (d != 0 || wr_m1 !== mdl_m1) begin
      failures++;
      $display("FAIL rst_mid_results diffs=%0d m1=%h want 0 %h", d, wr_m1, mdl_m1);
    end
  endtask

  initial begin
    test_reset();
    test_reuse_first();
    test_full_job();
    test_reuse_job();
    test_backpressure();
    test_gaps();
    test_spurious();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
